// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote,
// false-start rejection, optional parity, 1/2 stop bits and a one-entry output buffer.
module uart_rx_frame #(
  parameter int CLOCK_PERIOD      = 10_000_000,
  parameter int BAUD_RATE         = 115_200,
  parameter int BAUD_PERIOD_COUNT = CLOCK_PERIOD / BAUD_RATE,
  parameter int DATA_BITS         = 8,
  parameter int PARITY_EN         = 0,
  parameter int PARITY_ODD        = 0,
  parameter int STOP_BITS         = 1
) (
  input  logic                 iCLK,
  input  logic                 iRESETn,
  input  logic                 iUART_RX,
  input  logic                 iRX_READY,
  output logic [DATA_BITS-1:0] oRX_DATA,
  output logic                 oRX_VALID,
  output logic                 oFRAME_ERR,
  output logic                 oPARITY_ERR,
  output logic                 oOVERRUN,
  output logic                 oRX_BUSY
);

  localparam int HALF = BAUD_PERIOD_COUNT / 2;
  localparam int CW   = $clog2(BAUD_PERIOD_COUNT);
  localparam logic [CW-1:0] LAST  = CW'(BAUD_PERIOD_COUNT - 1);
  localparam logic [CW-1:0] SMP0  = CW'(HALF - 1);
  localparam logic [CW-1:0] SMP1  = CW'(HALF);
  localparam logic [CW-1:0] DEC   = CW'(HALF + 1);
  localparam logic [3:0]    LASTD = 4'(DATA_BITS - 1);
  localparam logic          LASTS = 1'(STOP_BITS - 1);
  localparam logic          PODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {ARM, IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, stateNext;
  logic                   rxMeta, rxs, rxsPrev;
  logic [CW-1:0]          bitCnt, armCnt;
  logic [3:0]             bitIdx;
  logic                   stopIdx;
  logic                   s0, s1;
  logic [DATA_BITS-1:0]   shiftReg;
  logic                   frameErr, parErr;
  logic                   maj, decide, wrap, complete, frameBad, handshake;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rxMeta  <= 1'b1;
      rxs     <= 1'b1;
      rxsPrev <= 1'b1;
    end else begin
      rxMeta  <= iUART_RX;
      rxs     <= rxMeta;
      rxsPrev <= rxs;
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) state <= ARM;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    complete  = 1'b0;
    maj       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    decide    = (bitCnt == DEC);
    wrap      = (bitCnt == LAST);
    // Final stop bit's own sample is not yet in frameErr at its decision cycle.
    frameBad  = frameErr | ~maj;
    handshake = oRX_VALID & iRX_READY;
    case (state)
      ARM:    if (rxs && armCnt == LAST) stateNext = IDLE;
      IDLE:   if (rxsPrev && !rxs) stateNext = START;
      START: begin
        if (decide && maj) stateNext = IDLE;
        else if (wrap)     stateNext = DATA;
      end
      DATA:   if (wrap && bitIdx == LASTD) stateNext = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (wrap) stateNext = STOP;
      STOP: begin
        if (decide && stopIdx == LASTS) begin
          complete  = 1'b1;
          stateNext = frameBad ? ARM : IDLE;
        end
      end
      default: stateNext = ARM;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      armCnt   <= '0;
      bitCnt   <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      bitIdx   <= '0;
      stopIdx  <= 1'b0;
      shiftReg <= '0;
      frameErr <= 1'b0;
      parErr   <= 1'b0;
    end else begin
      if (state == ARM && rxs && armCnt != LAST) armCnt <= armCnt + 1'b1;
      else                                       armCnt <= '0;

      if (state == IDLE || stateNext == IDLE || stateNext == ARM || wrap) bitCnt <= '0;
      else                                                              bitCnt <= bitCnt + 1'b1;

      if (bitCnt == SMP0) s0 <= rxs;
      if (bitCnt == SMP1) s1 <= rxs;

      case (state)
        START: begin
          bitIdx   <= '0;
          stopIdx  <= 1'b0;
          frameErr <= 1'b0;
          parErr   <= 1'b0;
        end
        DATA: begin
          if (decide) shiftReg <= {maj, shiftReg[DATA_BITS-1:1]};
          if (wrap)   bitIdx   <= bitIdx + 1'b1;
        end
        PARITY: if (decide) parErr <= (((^shiftReg) ^ maj) != PODD);
        STOP: begin
          if (decide && !maj) frameErr <= 1'b1;
          if (wrap)           stopIdx  <= stopIdx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A completion coinciding with a handshake reloads the buffer and is never an overrun.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      oRX_DATA    <= '0;
      oRX_VALID   <= 1'b0;
      oFRAME_ERR  <= 1'b0;
      oPARITY_ERR <= 1'b0;
      oOVERRUN    <= 1'b0;
    end else if (complete) begin
      if (!oRX_VALID || iRX_READY) begin
        oRX_DATA    <= shiftReg;
        oFRAME_ERR  <= frameBad;
        oPARITY_ERR <= parErr;
        oRX_VALID   <= 1'b1;
        if (handshake) oOVERRUN <= 1'b0;
      end else begin
        oOVERRUN <= 1'b1;
      end
    end else if (handshake) begin
      oRX_VALID   <= 1'b0;
      oFRAME_ERR  <= 1'b0;
      oPARITY_ERR <= 1'b0;
      oOVERRUN    <= 1'b0;
    end
  end

  assign oRX_BUSY = (state != ARM) && (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 instance and an 8E2 instance, both at 16 clocks per bit.
module tb_uart_rx_frame;

  localparam int BPC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic       rxA, rxB, rdyA, rdyB;
  logic [7:0] dataA, dataB;
  logic       validA, ferrA, perrA, ovrA, busyA;
  logic       validB, ferrB, perrB, ovrB, busyB;

  uart_rx_frame #(.BAUD_PERIOD_COUNT(BPC), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dutA (
    .iCLK(clk), .iRESETn(rstN), .iUART_RX(rxA), .iRX_READY(rdyA),
    .oRX_DATA(dataA), .oRX_VALID(validA), .oFRAME_ERR(ferrA), .oPARITY_ERR(perrA),
    .oOVERRUN(ovrA), .oRX_BUSY(busyA));

  uart_rx_frame #(.BAUD_PERIOD_COUNT(BPC), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dutB (
    .iCLK(clk), .iRESETn(rstN), .iUART_RX(rxB), .iRX_READY(rdyB),
    .oRX_DATA(dataB), .oRX_VALID(validB), .oFRAME_ERR(ferrB), .oPARITY_ERR(perrB),
    .oOVERRUN(ovrB), .oRX_BUSY(busyB));

  typedef struct packed {logic [7:0] d; logic fe; logic pe;} word_t;
  typedef struct {int dut; logic [7:0] data; logic parBit; logic [1:0] stops;
                  logic [7:0] expD; logic expFe; logic expPe;} vec_t;

  word_t qA[$], qB[$];
  int    busyCntA = 0, busyCntB = 0;
  int    checks = 0, fails = 0;

  // Every accepted word (valid & ready) is captured here.
  always @(negedge clk) begin
    if (validA && rdyA) qA.push_back('{dataA, ferrA, perrA});
    if (validB && rdyB) qB.push_back('{dataB, ferrB, perrB});
    if (busyA) busyCntA++;
    if (busyB) busyCntB++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic setLine(input int which, input logic v);
    if (which == 0) rxA = v; else rxB = v;
  endtask

  // Drives start, 8 data bits LSB first, parity (B only) and stop bits; upTo<0 sends all.
  task automatic sendFrame(input int which, input logic [7:0] d, input logic parBit,
                           input logic [1:0] stops, input int upTo);
    logic [11:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (which == 1) begin bits[n] = parBit; n = n + 1; end
    bits[n] = stops[0]; n = n + 1;
    if (which == 1) begin bits[n] = stops[1]; n = n + 1; end
    if (upTo >= 0) n = upTo;
    for (int i = 0; i < n; i++) begin
      setLine(which, bits[i]);
      tick(BPC);
    end
    setLine(which, 1'b1);
  endtask

  function automatic word_t model(input logic [7:0] d, input bit parEn, input bit parOdd,
                                  input logic parBit, input logic [1:0] stops, input int nStop);
    word_t w;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (parEn) ones += int'(parBit);
    w.d  = d;
    w.pe = parEn && ((ones % 2) != (parOdd ? 1 : 0));
    w.fe = (stops[0] == 1'b0) || (nStop == 2 && stops[1] == 1'b0);
    return w;
  endfunction

  task automatic checkWord(input int which, input word_t e, input string tag);
    word_t w;
    int n;
    n = (which == 0) ? qA.size() : qB.size();
    check({tag, " count"}, n, 1);
    if (n > 0) begin
      if (which == 0) w = qA.pop_front(); else w = qB.pop_front();
      check({tag, " data"}, w.d, e.d);
      check({tag, " frameErr"}, w.fe, e.fe);
      check({tag, " parityErr"}, w.pe, e.pe);
    end
    if (which == 0) begin qA.delete(); check({tag, " overrun"}, ovrA, 0); end
    else begin qB.delete(); check({tag, " overrun"}, ovrB, 0); end
  endtask

  vec_t  tbl[10];
  word_t e;

  initial begin
    tbl[0] = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{0, 8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{0, 8'h3C, 1'b0, 2'b10, 8'h3C, 1'b1, 1'b0};
    tbl[4] = '{1, 8'h03, 1'b1, 2'b11, 8'h03, 1'b0, 1'b1};
    tbl[5] = '{1, 8'h03, 1'b0, 2'b11, 8'h03, 1'b0, 1'b0};
    tbl[6] = '{1, 8'h5A, 1'b0, 2'b01, 8'h5A, 1'b1, 1'b0};
    tbl[7] = '{1, 8'h80, 1'b1, 2'b11, 8'h80, 1'b0, 1'b0};
    tbl[8] = '{1, 8'h80, 1'b0, 2'b11, 8'h80, 1'b0, 1'b1};
    tbl[9] = '{1, 8'hFF, 1'b0, 2'b10, 8'hFF, 1'b1, 1'b0};

    rstN = 1'b0; rxA = 1'b1; rxB = 1'b1; rdyA = 1'b1; rdyB = 1'b1;
    tick(3);
    check("reset validA", validA, 0);
    check("reset dataA", dataA, 0);
    check("reset flagsA", {ferrA, perrA, ovrA, busyA}, 0);
    check("reset validB", validB, 0);
    check("reset flagsB", {ferrB, perrB, ovrB, busyB}, 0);
    rstN = 1'b1;
    tick(32);

    for (int i = 0; i < 10; i++) begin
      sendFrame(tbl[i].dut, tbl[i].data, tbl[i].parBit, tbl[i].stops, -1);
      tick(3 * BPC);
      checkWord(tbl[i].dut, '{tbl[i].expD, tbl[i].expFe, tbl[i].expPe}, $sformatf("vec%0d", i));
    end

    // Short glitch: START for exactly ten cycles, rejected at count 9.
    busyCntA = 0;
    rxA = 1'b0; tick(4); rxA = 1'b1;
    tick(2);
    check("glitch busy", busyA, 1);
    tick(20);
    check("glitch busyCycles", busyCntA, 10);
    check("glitch busyEnd", busyA, 0);
    check("glitch noWord", qA.size(), 0);

    // Break on the second stop bit parks B in ARM; a frame started inside the window is ignored.
    sendFrame(1, 8'h5A, 1'b0, 2'b01, -1);
    tick(8);
    checkWord(1, '{8'h5A, 1'b1, 1'b0}, "arm errFrame");
    busyCntB = 0;
    sendFrame(1, 8'h00, 1'b0, 2'b11, -1);
    tick(3 * BPC);
    check("arm ignoredStart", qB.size(), 0);
    check("arm neverBusy", busyCntB, 0);
    sendFrame(1, 8'hC3, 1'b0, 2'b11, -1);
    tick(3 * BPC);
    checkWord(1, '{8'hC3, 1'b0, 1'b0}, "arm recover");

    // Overrun: second frame dropped while the buffer is held.
    rdyA = 1'b0;
    sendFrame(0, 8'h11, 1'b0, 2'b11, -1);
    tick(3 * BPC);
    check("ovr firstValid", validA, 1);
    check("ovr firstNoOvr", ovrA, 0);
    sendFrame(0, 8'h22, 1'b0, 2'b11, -1);
    tick(3 * BPC);
    check("ovr data", dataA, 8'h11);
    check("ovr valid", validA, 1);
    check("ovr flag", ovrA, 1);
    rdyA = 1'b1; tick(1); rdyA = 1'b0;
    tick(1);
    check("ovr validCleared", validA, 0);
    check("ovr flagCleared", ovrA, 0);
    checkWord(0, '{8'h11, 1'b0, 1'b0}, "ovr accepted");
    rdyA = 1'b1;

    // Reset in the middle of data bit 4.
    sendFrame(0, 8'h3C, 1'b0, 2'b11, 5);
    rxA = 1'b1;
    tick(8);
    rstN = 1'b0; tick(3);
    check("midRst outputs", {validA, ferrA, perrA, ovrA, busyA}, 0);
    check("midRst data", dataA, 0);
    rstN = 1'b1;
    tick(2 * BPC);
    check("midRst noWord", qA.size(), 0);
    sendFrame(0, 8'h3C, 1'b0, 2'b11, -1);
    tick(3 * BPC);
    checkWord(0, '{8'h3C, 1'b0, 1'b0}, "midRst next");

    // Random frames against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      logic [1:0] st;
      logic       pb;
      d  = 8'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      sendFrame(1, d, pb, st, -1);
      tick(3 * BPC);
      e = model(d, 1'b1, 1'b0, pb, st, 2);
      checkWord(1, e, $sformatf("randB%0d", i));
      d  = 8'($urandom);
      st = {1'b1, ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1};
      sendFrame(0, d, 1'b0, st, -1);
      tick(3 * BPC);
      e = model(d, 1'b0, 1'b0, 1'b0, st, 1);
      checkWord(0, e, $sformatf("randA%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
